// File: rtl/jpeg_block_serializer_pp.sv
// Double-buffered DIM x DIM block serializer: two ping-pong banks, one output
// register slice, raster or transposed element order chosen per block.
module jpeg_block_serializer_pp #(
  parameter int DATA_W    = 8,
  parameter int OUT_W     = 9,
  parameter int DIM       = 8,
  parameter int SIGNED_IN = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          block_valid,
  input  logic [DATA_W*DIM*DIM-1:0]     block_in,
  input  logic                          order_sel,
  output logic                          block_ready,
  output logic                          pixel_valid,
  input  logic                          pixel_ready,
  output logic [OUT_W-1:0]              pixel_out,
  output logic                          pixel_last,
  output logic [$clog2(DIM*DIM)-1:0]    pixel_idx
);

  localparam int BLOCK_N = DIM * DIM;
  localparam int IDX_W   = $clog2(BLOCK_N);
  localparam int LOG_DIM = $clog2(DIM);

  logic [DATA_W*BLOCK_N-1:0] bank_q [2];
  logic [1:0]                full_q;
  logic [1:0]                order_q;
  logic                      wr_bank_q;
  logic                      rd_bank_q;
  logic [IDX_W-1:0]          idx_q;
  logic [IDX_W-1:0]          addr;
  logic [DATA_W-1:0]         elem;
  logic [OUT_W-1:0]          elem_ext;
  logic                      accept;
  logic                      load;
  logic                      load_last;

  assign block_ready = ~full_q[wr_bank_q];
  assign accept      = block_valid && block_ready;
  assign load        = full_q[rd_bank_q] && (!pixel_valid || pixel_ready);
  assign load_last   = load && (&idx_q);

  // Transposed order swaps the row and column fields of the sequence number.
  assign addr = order_q[rd_bank_q] ? {idx_q[LOG_DIM-1:0], idx_q[IDX_W-1:LOG_DIM]}
                                   : idx_q;
  assign elem = bank_q[rd_bank_q][int'(addr)*DATA_W +: DATA_W];

  always_comb begin
    elem_ext = '0;
    elem_ext[DATA_W-1:0] = elem;
    for (int i = DATA_W; i < OUT_W; i++) begin
      elem_ext[i] = (SIGNED_IN != 0) ? elem[DATA_W-1] : 1'b0;
    end
  end

  // Bank payload needs no reset: the full flags decide whether it is live.
  always_ff @(posedge clk) begin
    if (accept) begin
      bank_q[wr_bank_q] <= block_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q      <= '0;
      order_q     <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      idx_q       <= '0;
      pixel_valid <= 1'b0;
      pixel_out   <= '0;
      pixel_last  <= 1'b0;
      pixel_idx   <= '0;
    end else begin
      if (accept) begin
        full_q[wr_bank_q]  <= 1'b1;
        order_q[wr_bank_q] <= order_sel;
        wr_bank_q          <= ~wr_bank_q;
      end
      if (load) begin
        pixel_valid <= 1'b1;
        pixel_out   <= elem_ext;
        pixel_idx   <= idx_q;
        pixel_last  <= load_last;
        idx_q       <= idx_q + 1'b1;
        // Accept and release never target the same bank in one cycle.
        if (load_last) begin
          full_q[rd_bank_q] <= 1'b0;
          rd_bank_q         <= ~rd_bank_q;
        end
      end else if (pixel_ready) begin
        pixel_valid <= 1'b0;
        pixel_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jpeg_block_serializer_pp.sv
// Bench for jpeg_block_serializer_pp: directed block sequences, a constant-fill
// vector table and a randomized backpressure run against a pixel-queue model.
module tb_jpeg_block_serializer_pp;

  localparam int DW = 8;
  localparam int OW = 9;
  localparam int D  = 8;
  localparam int BN = D * D;

  logic            clk = 1'b0;
  logic            rst;
  logic            block_valid;
  logic [DW*BN-1:0] block_in;
  logic            order_sel;
  logic            pixel_ready;
  logic            block_ready, pixel_valid, pixel_last;
  logic [OW-1:0]   pixel_out;
  logic [5:0]      pixel_idx;
  logic            block_ready_u, pixel_valid_u, pixel_last_u;
  logic [OW-1:0]   pixel_out_u;
  logic [5:0]      pixel_idx_u;

  jpeg_block_serializer_pp #(.DATA_W(DW), .OUT_W(OW), .DIM(D), .SIGNED_IN(1)) dut (
    .clk(clk), .rst(rst), .block_valid(block_valid), .block_in(block_in),
    .order_sel(order_sel), .block_ready(block_ready), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .pixel_out(pixel_out), .pixel_last(pixel_last),
    .pixel_idx(pixel_idx));

  jpeg_block_serializer_pp #(.DATA_W(DW), .OUT_W(OW), .DIM(D), .SIGNED_IN(0)) dut_u (
    .clk(clk), .rst(rst), .block_valid(block_valid), .block_in(block_in),
    .order_sel(order_sel), .block_ready(block_ready_u), .pixel_valid(pixel_valid_u),
    .pixel_ready(pixel_ready), .pixel_out(pixel_out_u), .pixel_last(pixel_last_u),
    .pixel_idx(pixel_idx_u));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit rand_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [8:0] s;
    logic [8:0] u;
    int         idx;
    bit         last;
  } exp_t;

  exp_t q[$];
  int   acc_blocks = 0;
  int   presented  = 0;
  logic prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
  logic [8:0] prev_out = '0, prev_out_u = '0;
  logic [5:0] prev_idx = '0;

  function automatic logic [8:0] sext(input int v);
    return 9'((v >= 128) ? v + 256 : v);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      acc_blocks = 0;
      presented  = 0;
      prev_valid = 1'b0;
    end else begin
      chk("u_valid_match", pixel_valid_u, pixel_valid);
      chk("u_ready_match", block_ready_u, block_ready);
      if (pixel_valid) begin
        if (!prev_valid || prev_ready) begin
          if (q.size() == 0) begin
            chk("pixel_unexpected", 1, 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("sb_out_s", pixel_out, e.s);
            chk("sb_out_u", pixel_out_u, e.u);
            chk("sb_idx", pixel_idx, e.idx);
            chk("sb_last", pixel_last, e.last);
            chk("sb_idx_u", pixel_idx_u, e.idx);
            chk("sb_last_u", pixel_last_u, e.last);
          end
          presented++;
        end else begin
          chk("stall_out", pixel_out, prev_out);
          chk("stall_out_u", pixel_out_u, prev_out_u);
          chk("stall_idx", pixel_idx, prev_idx);
          chk("stall_last", pixel_last, prev_last);
        end
      end
      chk("block_ready_model", block_ready, (acc_blocks - presented / BN) < 2);
      if (block_valid && block_ready) begin
        for (int i = 0; i < BN; i++) begin
          exp_t e;
          int a, v;
          a = order_sel ? (i % D) * D + i / D : i;
          v = int'(block_in[a*DW +: DW]);
          e.s = sext(v);
          e.u = 9'(v);
          e.idx = i;
          e.last = (i == BN - 1);
          q.push_back(e);
        end
        acc_blocks++;
      end
      prev_valid = pixel_valid;
      prev_ready = pixel_ready;
      prev_out   = pixel_out;
      prev_out_u = pixel_out_u;
      prev_idx   = pixel_idx;
      prev_last  = pixel_last;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_mode) pixel_ready = 1'($urandom_range(0, 1));
  endtask

  // mode 0: element k = k, 1: constant c, 2: random
  task automatic fill_block(input int mode, input logic [7:0] c);
    for (int k = 0; k < BN; k++) begin
      case (mode)
        0:       block_in[k*DW +: DW] = 8'(k);
        1:       block_in[k*DW +: DW] = c;
        default: block_in[k*DW +: DW] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  task automatic send(input bit ord);
    int n;
    n = 0;
    block_valid = 1'b1;
    order_sel   = ord;
    while (!block_ready && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) chk("send_timeout", 0, 1);
    step();
    block_valid = 1'b0;
    order_sel   = 1'($urandom_range(0, 1));
    fill_block(2, 8'h00);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!pixel_valid && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("wait_valid_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || pixel_valid) && n < 5000) begin
      step();
      n++;
    end
    chk("drain_done", (q.size() == 0) && !pixel_valid, 1);
  endtask

  typedef struct {
    logic [7:0] fill;
    bit         ord;
    logic [8:0] exp_s;
    logic [8:0] exp_u;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int vcount, n;
    vecs[0] = '{8'h80, 1'b0, 9'h180, 9'h080};
    vecs[1] = '{8'h7f, 1'b1, 9'h07f, 9'h07f};
    vecs[2] = '{8'hff, 1'b0, 9'h1ff, 9'h0ff};
    vecs[3] = '{8'h00, 1'b1, 9'h000, 9'h000};
    vecs[4] = '{8'h01, 1'b0, 9'h001, 9'h001};

    rst = 1'b1; block_valid = 1'b0; order_sel = 1'b0; pixel_ready = 1'b1;
    block_in = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", pixel_valid, 0);
    chk("rst_out", pixel_out, 0);
    chk("rst_last", pixel_last, 0);
    chk("rst_idx", pixel_idx, 0);
    chk("rst_block_ready", block_ready, 1);

    // raster k=k, latency and last flag
    fill_block(0, 8'h00);
    send(1'b0);
    chk("lat_not_yet", pixel_valid, 0);
    step();
    for (int i = 0; i < BN; i++) begin
      chk("t1_valid", pixel_valid, 1);
      chk("t1_out", pixel_out, i);
      chk("t1_idx", pixel_idx, i);
      chk("t1_last", pixel_last, i == BN - 1);
      chk("t1_block_ready", block_ready, 1);
      step();
    end
    chk("t1_idle", pixel_valid, 0);

    // constant-fill extension table
    for (int v = 0; v < 5; v++) begin
      fill_block(1, vecs[v].fill);
      send(vecs[v].ord);
      wait_valid();
      for (int i = 0; i < BN; i++) begin
        chk("vec_out_s", pixel_out, vecs[v].exp_s);
        chk("vec_out_u", pixel_out_u, vecs[v].exp_u);
        step();
      end
      drain();
    end

    // transposed k=k
    fill_block(0, 8'h00);
    send(1'b1);
    wait_valid();
    for (int i = 0; i < BN; i++) begin
      chk("t3_out", pixel_out, (i % D) * D + i / D);
      chk("t3_idx", pixel_idx, i);
      step();
    end
    drain();

    // two back-to-back blocks, third blocked until first block's last load
    fill_block(0, 8'h00);
    send(1'b0);
    fill_block(2, 8'h00);
    send(1'b1);
    chk("t4_full_ready", block_ready, 0);
    chk("t4_first_valid", pixel_valid, 1);
    vcount = pixel_valid ? 1 : 0;
    fill_block(2, 8'h00);
    block_valid = 1'b1;
    order_sel = 1'b0;
    n = 0;
    while (!block_ready && n < 200) begin
      step();
      n++;
      if (pixel_valid) vcount++;
    end
    chk("t4_blocked_cycles", n, BN - 1);
    chk("t4_release_last", pixel_last, 1);
    chk("t4_release_idx", pixel_idx, BN - 1);
    step();
    block_valid = 1'b0;
    if (pixel_valid) vcount++;
    for (int i = 0; i < BN - 1; i++) begin
      step();
      if (pixel_valid) vcount++;
    end
    chk("t4_contig_valid", vcount, 2 * BN);
    chk("t4_last_b2", pixel_last, 1);
    step();
    chk("t4_b3_no_bubble", pixel_valid, 1);
    chk("t4_b3_idx0", pixel_idx, 0);
    drain();

    // random data, random order, random backpressure
    rand_mode = 1;
    for (int b = 0; b < 6; b++) begin
      fill_block(2, 8'h00);
      send(1'($urandom_range(0, 1)));
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
    end
    drain();
    rand_mode = 0;
    pixel_ready = 1'b1;
    step();

    // reset mid-block with the second bank full
    fill_block(2, 8'h00);
    send(1'b0);
    fill_block(2, 8'h00);
    send(1'b1);
    n = 0;
    while (!(pixel_valid && pixel_idx == 6'd20) && n < 100) begin
      step();
      n++;
    end
    chk("t6_reach_idx20", pixel_idx, 20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_valid_after_rst", pixel_valid, 0);
    chk("t6_ready_after_rst", block_ready, 1);
    step(); step();
    chk("t6_no_more_pixels", pixel_valid, 0);
    fill_block(0, 8'h00);
    send(1'b0);
    wait_valid();
    chk("t6_restart_idx", pixel_idx, 0);
    chk("t6_restart_out", pixel_out, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
